// File: rtl/wb_write_arbiter_if.sv
// Purpose: producer-side result channels and the four register-file write ports.
// Latency: none, signal bundle only.
// Backpressure: o_ready per channel, driven by the arbiter.
interface wb_write_arbiter_if #(
   parameter int N_IN  = 6,
   parameter int WIDTH = 5
);
   logic [N_IN-1:0]       i_valid;
   logic [N_IN-1:0]       o_ready;
   logic [N_IN*WIDTH-1:0] i_waddr;
   logic [N_IN*32-1:0]    i_wdata;

   logic                  o_we0;
   logic                  o_we1;
   logic                  o_we2;
   logic                  o_we3;
   logic [WIDTH-1:0]      o_waddr0;
   logic [WIDTH-1:0]      o_waddr1;
   logic [WIDTH-1:0]      o_waddr2;
   logic [WIDTH-1:0]      o_waddr3;
   logic [31:0]           o_wdata0;
   logic [31:0]           o_wdata1;
   logic [31:0]           o_wdata2;
   logic [31:0]           o_wdata3;
   logic                  o_busy;

   // Execution-unit side: drives results, observes ready and the write ports.
   modport master (
      output i_valid, i_waddr, i_wdata,
      input  o_ready,
      input  o_we0, o_we1, o_we2, o_we3,
      input  o_waddr0, o_waddr1, o_waddr2, o_waddr3,
      input  o_wdata0, o_wdata1, o_wdata2, o_wdata3,
      input  o_busy
   );

   // Arbiter side.
   modport slave (
      input  i_valid, i_waddr, i_wdata,
      output o_ready,
      output o_we0, o_we1, o_we2, o_we3,
      output o_waddr0, o_waddr1, o_waddr2, o_waddr3,
      output o_wdata0, o_wdata1, o_wdata2, o_wdata3,
      output o_busy
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Purpose: generic per-channel result FIFO (count, wrap-around pointers).
// Latency: entry pushed at an edge is visible on head_dat right after that edge.
// Backpressure: caller must gate push_vld with count < DEPTH and pop_vld with count != 0.
module wb_write_fifo #(
   parameter  int W     = 37,
   parameter  int DEPTH = 2,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_vld,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage array; no reset needed, validity is tracked by count.
   always_ff @(posedge i_clk) begin
      if (push_vld) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push_vld, pop_vld})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

// Purpose: buffer N_IN result channels and grant up to 4 register-file writes per cycle, rotating priority.
// Latency: push at edge T -> earliest o_we at edge T+1 (registered write ports).
// Backpressure: o_ready[k] = registered count < DEPTH; a same-cycle pop does not raise it.
module wb_write_arbiter #(
   parameter int N_IN  = 6,
   parameter int WIDTH = 5,
   parameter int DEPTH = 2
) (
   input logic               i_clk,
   input logic               i_rst_n,
   wb_write_arbiter_if.slave bus
);
   localparam int RRW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int NP  = 4;

   typedef struct packed {
      logic [WIDTH-1:0] waddr;
      logic [31:0]      wdata;
   } entry_t;

   entry_t          head  [N_IN];
   logic [CW-1:0]   count [N_IN];
   logic [N_IN-1:0] push;
   logic [N_IN-1:0] pop;
   logic [N_IN-1:0] nonempty;
   logic [N_IN-1:0] ready;
   logic [RRW-1:0]  rr;

   // Grant bookkeeping, all produced by the selection process.
   logic            slot_vld [NP];
   entry_t          slot_ent [NP];
   logic [2:0]      n_gnt;
   logic [RRW-1:0]  last_ch;
   logic            any_gnt;
   logic [RRW:0]    scan_sum;
   logic [RRW-1:0]  scan_ch;
   logic            hit;

   // Registered write ports.
   logic            we_q    [NP];
   logic [WIDTH-1:0] waddr_q [NP];
   logic [31:0]     wdata_q [NP];

   genvar k;
   for (k = 0; k < N_IN; k++) begin : g_ch
      entry_t in_ent;
      assign in_ent.waddr = bus.i_waddr[k*WIDTH +: WIDTH];
      assign in_ent.wdata = bus.i_wdata[k*32 +: 32];
      assign ready[k]     = (count[k] < CW'(DEPTH));
      assign nonempty[k]  = (count[k] != '0);
      assign push[k]      = bus.i_valid[k] & ready[k];

      wb_write_fifo #(
         .W     ($bits(entry_t)),
         .DEPTH (DEPTH)
      ) u_fifo (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .push_vld (push[k]),
         .push_dat (in_ent),
         .pop_vld  (pop[k]),
         .head_dat (head[k]),
         .count    (count[k])
      );
   end

   // Rotating scan over the FIFO heads: grant in order, skip heads whose address is already granted, stop at 4.
   always_comb begin
      pop      = '0;
      n_gnt    = '0;
      last_ch  = rr;
      any_gnt  = 1'b0;
      scan_sum = '0;
      scan_ch  = '0;
      hit      = 1'b0;
      for (int s = 0; s < NP; s++) begin
         slot_vld[s] = 1'b0;
         slot_ent[s] = '0;
      end
      for (int i = 0; i < N_IN; i++) begin
         scan_sum = {1'b0, rr} + (RRW+1)'(i);
         if (scan_sum >= (RRW+1)'(N_IN)) scan_sum = scan_sum - (RRW+1)'(N_IN);
         scan_ch = scan_sum[RRW-1:0];
         hit = 1'b0;
         for (int s = 0; s < NP; s++) begin
            if (slot_vld[s] && (slot_ent[s].waddr == head[scan_ch].waddr)) hit = 1'b1;
         end
         if ((n_gnt < 3'(NP)) && nonempty[scan_ch] && !hit) begin
            slot_vld[n_gnt[1:0]] = 1'b1;
            slot_ent[n_gnt[1:0]] = head[scan_ch];
            pop[scan_ch]         = 1'b1;
            last_ch              = scan_ch;
            any_gnt              = 1'b1;
            n_gnt                = n_gnt + 3'd1;
         end
      end
   end

   // Round-robin pointer moves past the last granted channel; unchanged on an idle cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rr <= '0;
      end else if (any_gnt) begin
         rr <= (last_ch == RRW'(N_IN - 1)) ? '0 : last_ch + 1'b1;
      end
   end

   // Write-port registers: granted slots load their entry (x0 loads with we=0), idle slots drop we and hold addr/data.
   always_ff @(posedge i_clk) begin
      for (int s = 0; s < NP; s++) begin
         if (!i_rst_n) begin
            we_q[s]    <= 1'b0;
            waddr_q[s] <= '0;
            wdata_q[s] <= '0;
         end else if (slot_vld[s]) begin
            we_q[s]    <= (slot_ent[s].waddr != '0);
            waddr_q[s] <= slot_ent[s].waddr;
            wdata_q[s] <= slot_ent[s].wdata;
         end else begin
            we_q[s]    <= 1'b0;
         end
      end
   end

   assign bus.o_ready  = ready;
   assign bus.o_we0    = we_q[0];
   assign bus.o_we1    = we_q[1];
   assign bus.o_we2    = we_q[2];
   assign bus.o_we3    = we_q[3];
   assign bus.o_waddr0 = waddr_q[0];
   assign bus.o_waddr1 = waddr_q[1];
   assign bus.o_waddr2 = waddr_q[2];
   assign bus.o_waddr3 = waddr_q[3];
   assign bus.o_wdata0 = wdata_q[0];
   assign bus.o_wdata1 = wdata_q[1];
   assign bus.o_wdata2 = wdata_q[2];
   assign bus.o_wdata3 = wdata_q[3];
   assign bus.o_busy   = (|nonempty) | we_q[0] | we_q[1] | we_q[2] | we_q[3];
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Purpose: self-checking bench for wb_write_arbiter (vector table, directed corner sequences, random vs queue model).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: producers hold valid/addr/data until accepted.
module tb_wb_write_arbiter;
   localparam int N = 6;
   localparam int W = 5;
   localparam int D = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   wb_write_arbiter_if #(.N_IN(N), .WIDTH(W)) bus ();

   wb_write_arbiter #(.N_IN(N), .WIDTH(W), .DEPTH(D)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]   valid;
      logic [N*W-1:0] addr;
      logic [3:0]     exp_we;
      logic [11:0]    exp_ch;
      logic           exp_busy;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [31:0]  d;
   } ent_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_valid = '0;
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [3:0] we_mask();
      return {bus.o_we3, bus.o_we2, bus.o_we1, bus.o_we0};
   endfunction

   function automatic logic [W-1:0] get_wa(input int s);
      case (s)
         0:       return bus.o_waddr0;
         1:       return bus.o_waddr1;
         2:       return bus.o_waddr2;
         default: return bus.o_waddr3;
      endcase
   endfunction

   function automatic logic [31:0] get_wd(input int s);
      case (s)
         0:       return bus.o_wdata0;
         1:       return bus.o_wdata1;
         2:       return bus.o_wdata2;
         default: return bus.o_wdata3;
      endcase
   endfunction

   function automatic logic [N*W-1:0] pa(input int a0, a1, a2, a3, a4, a5);
      return {5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
   endfunction

   function automatic logic [11:0] pch(input int c0, c1, c2, c3);
      return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
   endfunction

   function automatic logic [31:0] vdat(input int v, input int ch);
      return 32'hC0DE_0000 | (32'(v) << 8) | 32'(ch);
   endfunction

   vec_t        vecs [9];
   logic [31:0] got3 [$];
   ent_t        mq   [N][$];
   logic        m_we [4];
   logic [W-1:0] m_wa [4];
   logic [31:0] m_wd [4];

   initial begin
      int          acc3;
      int          first_drop;
      int          n10;
      logic        take3;
      logic [3:0]  m;
      int          c;
      logic        pend [N];
      logic [W-1:0] p_a [N];
      logic [31:0] p_d [N];
      logic        acc [N];
      int          gch [$];
      logic [W-1:0] gad [$];
      int          m_rr;
      logic        do_rst;
      logic        dup;
      logic        mbusy;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.i_valid = '0;
      bus.i_waddr = '0;
      bus.i_wdata = '0;

      vecs[0] = '{6'b000100, pa(0, 0, 7, 0, 0, 0),     4'b0001, pch(2, 0, 0, 0), 1'b1};
      vecs[1] = '{6'b111111, pa(1, 2, 3, 4, 5, 6),     4'b1111, pch(0, 1, 2, 3), 1'b1};
      vecs[2] = '{6'b000011, pa(9, 9, 0, 0, 0, 0),     4'b0001, pch(0, 0, 0, 0), 1'b1};
      vecs[3] = '{6'b000011, pa(0, 3, 0, 0, 0, 0),     4'b0010, pch(0, 1, 0, 0), 1'b1};
      vecs[4] = '{6'b101010, pa(0, 2, 0, 4, 0, 4),     4'b0011, pch(1, 3, 0, 0), 1'b1};
      vecs[5] = '{6'b111111, pa(5, 5, 5, 5, 5, 5),     4'b0001, pch(0, 0, 0, 0), 1'b1};
      vecs[6] = '{6'b110000, pa(0, 0, 0, 0, 31, 30),   4'b0011, pch(4, 5, 0, 0), 1'b1};
      vecs[7] = '{6'b000000, pa(0, 0, 0, 0, 0, 0),     4'b0000, pch(0, 0, 0, 0), 1'b0};
      vecs[8] = '{6'b001000, pa(0, 0, 0, 0, 0, 0),     4'b0000, pch(0, 0, 0, 0), 1'b0};

      // Reset state.
      step();
      step();
      rst_n = 1'b1;
      chk("rst_we",    we_mask(), 4'b0000);
      chk("rst_waddr0", bus.o_waddr0, 0);
      chk("rst_wdata0", bus.o_wdata0, 0);
      chk("rst_ready", bus.o_ready, 6'b111111);
      chk("rst_busy",  bus.o_busy, 0);

      // Single-cycle selection vectors from a fresh reset (rr=0).
      for (int v = 0; v < 9; v++) begin
         do_reset();
         bus.i_valid = vecs[v].valid;
         bus.i_waddr = vecs[v].addr;
         for (int k = 0; k < N; k++) bus.i_wdata[k*32 +: 32] = vdat(v, k);
         step();
         bus.i_valid = '0;
         step();
         chk("vec_we", we_mask(), vecs[v].exp_we);
         for (int s = 0; s < 4; s++) begin
            if (vecs[v].exp_we[s]) begin
               c = int'(vecs[v].exp_ch[s*3 +: 3]);
               chk("vec_waddr", get_wa(s), vecs[v].addr[c*W +: W]);
               chk("vec_wdata", get_wd(s), vdat(v, c));
            end
         end
         chk("vec_busy", bus.o_busy, vecs[v].exp_busy);
      end

      // Reset mid-stream discards buffered entries.
      do_reset();
      bus.i_valid = '1;
      bus.i_waddr = {N{5'd9}};
      for (int k = 0; k < N; k++) bus.i_wdata[k*32 +: 32] = 32'hF111_0000 | 32'(k);
      step();
      step();
      chk("fill_ready1", bus.o_ready[1], 0);
      chk("fill_ready0", bus.o_ready[0], 1);
      chk("fill_busy",   bus.o_busy, 1);
      bus.i_valid = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_we",    we_mask(), 4'b0000);
      chk("midrst_ready", bus.o_ready, 6'b111111);
      chk("midrst_busy",  bus.o_busy, 0);
      step();
      chk("midrst_we_next",   we_mask(), 4'b0000);
      chk("midrst_busy_next", bus.o_busy, 0);

      // Single write latency.
      do_reset();
      bus.i_valid = 6'b000100;
      bus.i_waddr[2*W +: W] = 5'd7;
      bus.i_wdata[2*32 +: 32] = 32'hDEADBEEF;
      step();
      chk("single_we_early", we_mask(), 4'b0000);
      chk("single_busy",     bus.o_busy, 1);
      bus.i_valid = '0;
      step();
      chk("single_we",    we_mask(), 4'b0001);
      chk("single_waddr", bus.o_waddr0, 7);
      chk("single_wdata", bus.o_wdata0, 32'hDEADBEEF);
      step();
      chk("single_idle_busy", bus.o_busy, 0);

      // Six-way contention, then prove rr returned to 0 (only rr=0 puts ch0 ahead of ch5).
      do_reset();
      bus.i_valid = '1;
      bus.i_waddr = pa(1, 2, 3, 4, 5, 6);
      for (int k = 0; k < N; k++) bus.i_wdata[k*32 +: 32] = 32'h600 + 32'(k);
      step();
      bus.i_valid = '0;
      step();
      chk("six_we1", we_mask(), 4'b1111);
      for (int s = 0; s < 4; s++) chk("six_addr1", get_wa(s), s + 1);
      step();
      chk("six_we2", we_mask(), 4'b0011);
      chk("six_addr2_0", bus.o_waddr0, 5);
      chk("six_addr2_1", bus.o_waddr1, 6);
      chk("six_data2_1", bus.o_wdata1, 32'h605);
      bus.i_valid = 6'b100001;
      bus.i_waddr = pa(21, 0, 0, 0, 0, 20);
      step();
      bus.i_valid = '0;
      step();
      chk("six_rr0_slot0", bus.o_waddr0, 21);
      chk("six_rr0_slot1", bus.o_waddr1, 20);

      // Address conflict on x9.
      do_reset();
      bus.i_valid = 6'b000011;
      bus.i_waddr = pa(9, 9, 0, 0, 0, 0);
      bus.i_wdata[0 +: 32]  = 32'h11;
      bus.i_wdata[32 +: 32] = 32'h22;
      step();
      bus.i_valid = '0;
      step();
      chk("conf_we1",   we_mask(), 4'b0001);
      chk("conf_data1", bus.o_wdata0, 32'h11);
      step();
      chk("conf_we2",   we_mask(), 4'b0001);
      chk("conf_addr2", bus.o_waddr0, 9);
      chk("conf_data2", bus.o_wdata0, 32'h22);

      // Backpressure on channel 3 while 0,1,2,4 compete for the same address.
      do_reset();
      acc3 = 0;
      first_drop = -1;
      got3.delete();
      for (int cyc = 0; cyc < 80; cyc++) begin
         bus.i_valid = '0;
         if (cyc < 20) bus.i_valid = 6'b010111;
         bus.i_valid[3] = (acc3 < 4);
         bus.i_waddr = {N{5'd10}};
         for (int k = 0; k < N; k++)
            bus.i_wdata[k*32 +: 32] = (k == 3) ? 32'h3000_00A0 + 32'(acc3) : 32'h0000_1000 + 32'(k);
         if (bus.i_valid[3] && !bus.o_ready[3] && first_drop < 0) first_drop = acc3;
         take3 = bus.i_valid[3] && bus.o_ready[3];
         step();
         if (take3) acc3++;
         n10 = 0;
         m = we_mask();
         for (int s = 0; s < 4; s++) begin
            if (m[s] && get_wa(s) == 5'd10) begin
               n10++;
               if (get_wd(s) >= 32'h3000_0000) got3.push_back(get_wd(s));
            end
         end
         chk("bp_single_x10", (n10 <= 1), 1);
      end
      chk("bp_drop_after", first_drop, 2);
      chk("bp_accepts",    acc3, 4);
      chk("bp_retired",    got3.size(), 4);
      for (int i = 0; i < got3.size(); i++) chk("bp_order", got3[i], 32'h3000_00A0 + 32'(i));
      chk("bp_drained",    bus.o_busy, 0);

      // x0 drop.
      do_reset();
      bus.i_valid = 6'b000001;
      bus.i_waddr = '0;
      bus.i_wdata[0 +: 32] = 32'h55;
      step();
      chk("x0_busy_hi", bus.o_busy, 1);
      bus.i_valid = '0;
      step();
      chk("x0_we",     we_mask(), 4'b0000);
      chk("x0_busy_lo", bus.o_busy, 0);
      chk("x0_wdata0", bus.o_wdata0, 32'h55);

      // Random traffic against a queue model.
      do_reset();
      m_rr = 0;
      for (int k = 0; k < N; k++) begin
         mq[k].delete();
         pend[k] = 1'b0;
         p_a[k]  = '0;
         p_d[k]  = '0;
      end
      for (int s = 0; s < 4; s++) begin
         m_we[s] = 1'b0;
         m_wa[s] = '0;
         m_wd[s] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 99) < 55) begin
               pend[k] = 1'b1;
               p_a[k]  = 5'($urandom_range(0, 7));
               p_d[k]  = $urandom;
            end
            bus.i_valid[k] = pend[k];
            bus.i_waddr[k*W +: W] = p_a[k];
            bus.i_wdata[k*32 +: 32] = p_d[k];
         end
         do_rst = ($urandom_range(0, 299) == 0);
         rst_n = !do_rst;
         for (int k = 0; k < N; k++) begin
            chk("rand_ready", bus.o_ready[k], (mq[k].size() < D));
            acc[k] = pend[k] && (mq[k].size() < D) && !do_rst;
         end
         gch.delete();
         gad.delete();
         for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            dup = 1'b0;
            foreach (gad[j]) if (mq[c].size() > 0 && gad[j] == mq[c][0].a) dup = 1'b1;
            if (gch.size() < 4 && mq[c].size() > 0 && !dup) begin
               gch.push_back(c);
               gad.push_back(mq[c][0].a);
            end
         end
         step();
         rst_n = 1'b1;
         if (do_rst) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            for (int s = 0; s < 4; s++) begin
               m_we[s] = 1'b0;
               m_wa[s] = '0;
               m_wd[s] = '0;
            end
            m_rr = 0;
         end else begin
            for (int s = 0; s < 4; s++) begin
               if (s < gch.size()) begin
                  m_we[s] = (mq[gch[s]][0].a != 0);
                  m_wa[s] = mq[gch[s]][0].a;
                  m_wd[s] = mq[gch[s]][0].d;
               end else begin
                  m_we[s] = 1'b0;
               end
            end
            foreach (gch[j]) void'(mq[gch[j]].pop_front());
            if (gch.size() > 0) m_rr = (gch[gch.size()-1] + 1) % N;
            for (int k = 0; k < N; k++) begin
               if (acc[k]) begin
                  mq[k].push_back('{a: p_a[k], d: p_d[k]});
                  pend[k] = 1'b0;
               end
            end
         end
         mbusy = 1'b0;
         for (int k = 0; k < N; k++) if (mq[k].size() > 0) mbusy = 1'b1;
         m = we_mask();
         for (int s = 0; s < 4; s++) begin
            if (m_we[s]) mbusy = 1'b1;
            chk("rand_we",    m[s], m_we[s]);
            chk("rand_waddr", get_wa(s), m_wa[s]);
            chk("rand_wdata", get_wd(s), m_wd[s]);
            for (int t = s + 1; t < 4; t++)
               if (m[s] && m[t]) chk("rand_unique", (get_wa(s) != get_wa(t)), 1);
         end
         chk("rand_busy", bus.o_busy, mbusy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side arbiter that drives the four write ports of the 8-read/4-write integer register file.
- Collects results from N_IN execution-unit channels through valid/ready handshakes and buffers them in per-channel FIFOs.
- Grants up to four writes per cycle with rotating priority and presents them as registered we/waddr/wdata groups.
- Sits between the execution units' result buses and the register file.

Parameters:
- N_IN, 6, number of producer channels (legal range 4..8).
- WIDTH, 5, register address width; matches the register file WIDTH.
- DEPTH, 2, entries per channel FIFO (power of two).

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  N_IN  per-channel result valid.
- o_ready  output  N_IN  per-channel FIFO can accept.
- i_waddr  input  N_IN*WIDTH  destination register per channel; channel k occupies bits [k*WIDTH +: WIDTH].
- i_wdata  input  N_IN*32  result data per channel; channel k occupies bits [k*32 +: 32].
- o_we0..o_we3  output  1 each  write enable, port 0..3.
- o_waddr0..o_waddr3  output  WIDTH each  write address, port 0..3.
- o_wdata0..o_wdata3  output  32 each  write data, port 0..3.
- o_busy  output  1  high when any FIFO is non-empty or any o_we is asserted.

Behaviour:
- Clocking and reset:
  - Single clock i_clk; reset i_rst_n is synchronous and active-low.
  - Reset clears all FIFO counts and pointers, sets the round-robin pointer rr=0, and drives o_we*, o_waddr*, o_wdata* to 0.
  - A reset asserted mid-operation discards all buffered entries; no write is issued in the cycle after reset.
- Input handshake:
  - o_ready[k] = (count[k] < DEPTH), based on the registered count only.
  - A pop in the same cycle does not raise o_ready.
  - A push occurs when i_valid[k] && o_ready[k].
  - Producers must hold valid, addr and data stable until accepted.
- Ordering:
  - Entries within a channel retire strictly in FIFO order.
  - Across channels no order is guaranteed.
- Selection (combinational, each cycle, on FIFO heads):
  - Scan channels rr, rr+1, ..., rr+N_IN-1 (mod N_IN); stop after 4 grants.
  - A non-empty head is granted unless its waddr equals the waddr of a head already granted this cycle. A skipped head stays queued.
  - Grants fill output slots 0,1,2,3 in scan order.
  - Granted heads pop at the clock edge.
  - waddr==0 heads are granted and popped, but their slot drives o_we=0.
- Output register:
  - At each edge, slot s loads we/waddr/wdata from its grant.
  - Ungranted slots load we=0; waddr and wdata hold their previous values.
- Round-robin update:
  - If any grant occurred, rr becomes (last granted channel + 1) mod N_IN.
  - Otherwise rr is unchanged.
- Latency:
  - An entry pushed at edge T is earliest visible on o_we at the edge T+1, and is committed to the register file at edge T+2.
  - Minimum 2 edges from acceptance to commit.
- Push and pop together: a simultaneous push and pop on one channel leaves count unchanged. A full FIFO that pops still shows o_ready=0 that cycle.
- Address uniqueness: the four o_waddr values with o_we=1 in one cycle are always pairwise distinct.
- Throughput: sustains 4 writes/cycle when at least 4 channels hold distinct nonzero destinations.

Test Plan:
- Reset mid-stream: fill channels 0..5 with 2 entries each, pulse i_rst_n low for one cycle → o_we0..3=0 the next cycle, o_ready all 1, o_busy=0.
- Single write: channel 2 pushes addr 7, data 0xDEADBEEF at edge T → at edge T+1, o_we0=1, o_waddr0=7, o_wdata0=0xDEADBEEF; o_we1..3=0.
- Six-way contention: all 6 channels valid for one cycle, addrs 1..6, rr=0 → first cycle ports carry addrs 1,2,3,4; next cycle ports 0,1 carry addrs 5,6; rr ends at 0.
- Address conflict: channels 0 and 1 both target addr 9 (data 0x11 and 0x22) → cycle 1 writes only 0x11; cycle 2 writes 0x22; never two o_we on addr 9 in one cycle.
- Backpressure: channel 3 holds i_valid for 4 cycles while channels 0,1,2,4 stay busy → o_ready[3] drops after 2 accepts; all 4 values retire in push order; none lost or duplicated.
- x0 drop: push addr 0, data 0x55 → entry pops, all o_we=0, o_busy falls the following cycle.
